// File: rtl/car_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : car_frame_buffer
// Purpose  : Double-buffered store for one car snapshot. Serial node streams
//            (left wheel, right wheel, body, centre of mass) fill the back
//            bank. A frame with the right node counts is held until the
//            renderer's frame_sync, when the banks swap, so readers always
//            see a complete, tear-free car.
// Ports    : clk_in, rst_in (async, active-low)
//            left/right wheel and body streams (x, y, valid), com (x, y, valid)
//            all_done   - end of a manage_car update
//            frame_sync - renderer safe-swap point
//            car_wheel_1/2_x/y, car_body_x/y, camera_x/y - front bank
//            snapshot_valid, ready_for_update, frame_err_count, drop_count
// Revision : 1.0 - initial release
// ============================================================================
module car_frame_buffer #(
  parameter int POSITION_SIZE   = 17,
  parameter int NUM_WHEEL_NODES = 4,
  parameter int NUM_BODY_NODES  = 3,
  parameter int ERR_CNT_SIZE    = 8
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic signed [POSITION_SIZE-1:0] left_wheel_x,
  input  logic signed [POSITION_SIZE-1:0] left_wheel_y,
  input  logic                            left_wheel_valid,
  input  logic signed [POSITION_SIZE-1:0] right_wheel_x,
  input  logic signed [POSITION_SIZE-1:0] right_wheel_y,
  input  logic                            right_wheel_valid,
  input  logic signed [POSITION_SIZE-1:0] body_x,
  input  logic signed [POSITION_SIZE-1:0] body_y,
  input  logic                            body_valid,
  input  logic signed [POSITION_SIZE-1:0] com_x_in,
  input  logic signed [POSITION_SIZE-1:0] com_y_in,
  input  logic                            com_valid,
  input  logic                            all_done,
  input  logic                            frame_sync,
  output logic signed [POSITION_SIZE-1:0] car_wheel_1_x [NUM_WHEEL_NODES],
  output logic signed [POSITION_SIZE-1:0] car_wheel_1_y [NUM_WHEEL_NODES],
  output logic signed [POSITION_SIZE-1:0] car_wheel_2_x [NUM_WHEEL_NODES],
  output logic signed [POSITION_SIZE-1:0] car_wheel_2_y [NUM_WHEEL_NODES],
  output logic signed [POSITION_SIZE-1:0] car_body_x    [NUM_BODY_NODES],
  output logic signed [POSITION_SIZE-1:0] car_body_y    [NUM_BODY_NODES],
  output logic signed [POSITION_SIZE-1:0] camera_x,
  output logic signed [POSITION_SIZE-1:0] camera_y,
  output logic                            snapshot_valid,
  output logic                            ready_for_update,
  output logic        [ERR_CNT_SIZE-1:0]  frame_err_count,
  output logic        [ERR_CNT_SIZE-1:0]  drop_count
);

  localparam int WCNT_W = $clog2(NUM_WHEEL_NODES) + 1;
  localparam int BCNT_W = $clog2(NUM_BODY_NODES) + 1;
  localparam int WIDX_W = $clog2(NUM_WHEEL_NODES);
  localparam int BIDX_W = $clog2(NUM_BODY_NODES);
  localparam logic [WCNT_W-1:0] WHEEL_FULL = WCNT_W'(NUM_WHEEL_NODES);
  localparam logic [BCNT_W-1:0] BODY_FULL  = BCNT_W'(NUM_BODY_NODES);

  typedef enum logic [0:0] {
    FILL    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t state, state_next;

  // bank_ptr selects the front bank; the other bank is being filled.
  logic bank_ptr;
  logic back_sel;

  logic signed [POSITION_SIZE-1:0] lw_x [2][NUM_WHEEL_NODES];
  logic signed [POSITION_SIZE-1:0] lw_y [2][NUM_WHEEL_NODES];
  logic signed [POSITION_SIZE-1:0] rw_x [2][NUM_WHEEL_NODES];
  logic signed [POSITION_SIZE-1:0] rw_y [2][NUM_WHEEL_NODES];
  logic signed [POSITION_SIZE-1:0] bd_x [2][NUM_BODY_NODES];
  logic signed [POSITION_SIZE-1:0] bd_y [2][NUM_BODY_NODES];
  logic signed [POSITION_SIZE-1:0] cm_x [2];
  logic signed [POSITION_SIZE-1:0] cm_y [2];

  logic [WCNT_W-1:0] left_cnt, right_cnt;
  logic [BCNT_W-1:0] body_cnt;
  logic              left_ovf, right_ovf, body_ovf, com_seen;

  logic in_fill;
  logic left_wr, right_wr, body_wr, com_wr;
  logic left_hit_ovf, right_hit_ovf, body_hit_ovf;
  logic frame_end, frame_good, swap, any_valid;

  assign back_sel = ~bank_ptr;
  assign in_fill  = (state == FILL);

  assign left_wr       = in_fill && left_wheel_valid  && (left_cnt  != WHEEL_FULL);
  assign right_wr      = in_fill && right_wheel_valid && (right_cnt != WHEEL_FULL);
  assign body_wr       = in_fill && body_valid        && (body_cnt  != BODY_FULL);
  assign com_wr        = in_fill && com_valid;
  assign left_hit_ovf  = in_fill && left_wheel_valid  && (left_cnt  == WHEEL_FULL);
  assign right_hit_ovf = in_fill && right_wheel_valid && (right_cnt == WHEEL_FULL);
  assign body_hit_ovf  = in_fill && body_valid        && (body_cnt  == BODY_FULL);

  // The check folds in this cycle's pulses so nodes arriving together with
  // all_done still count toward the frame.
  assign frame_end  = in_fill && all_done;
  assign frame_good = ((left_cnt  + WCNT_W'(left_wr))  == WHEEL_FULL) &&
                      ((right_cnt + WCNT_W'(right_wr)) == WHEEL_FULL) &&
                      ((body_cnt  + BCNT_W'(body_wr))  == BODY_FULL)  &&
                      (com_seen || com_valid) &&
                      !(left_ovf  || left_hit_ovf  ||
                        right_ovf || right_hit_ovf ||
                        body_ovf  || body_hit_ovf);

  assign swap      = (state == PENDING) && frame_sync;
  assign any_valid = left_wheel_valid || right_wheel_valid || body_valid || com_valid;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= FILL;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (frame_end && frame_good) state_next = PENDING;
      PENDING: if (frame_sync)              state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // Stream counters, overflow flags, status counters and bank pointer.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      left_cnt        <= '0;
      right_cnt       <= '0;
      body_cnt        <= '0;
      left_ovf        <= 1'b0;
      right_ovf       <= 1'b0;
      body_ovf        <= 1'b0;
      com_seen        <= 1'b0;
      frame_err_count <= '0;
      drop_count      <= '0;
      bank_ptr        <= 1'b0;
      snapshot_valid  <= 1'b0;
    end else begin
      if (frame_end) begin
        left_cnt  <= '0;
        right_cnt <= '0;
        body_cnt  <= '0;
        left_ovf  <= 1'b0;
        right_ovf <= 1'b0;
        body_ovf  <= 1'b0;
        com_seen  <= 1'b0;
        if (!frame_good && (frame_err_count != '1))
          frame_err_count <= frame_err_count + 1'b1;
      end else begin
        if (left_wr)       left_cnt  <= left_cnt  + 1'b1;
        if (right_wr)      right_cnt <= right_cnt + 1'b1;
        if (body_wr)       body_cnt  <= body_cnt  + 1'b1;
        if (left_hit_ovf)  left_ovf  <= 1'b1;
        if (right_hit_ovf) right_ovf <= 1'b1;
        if (body_hit_ovf)  body_ovf  <= 1'b1;
        if (com_wr)        com_seen  <= 1'b1;
      end
      if ((state == PENDING) && any_valid && (drop_count != '1))
        drop_count <= drop_count + 1'b1;
      if (swap) begin
        bank_ptr       <= ~bank_ptr;
        snapshot_valid <= 1'b1;
      end
    end
  end

  // Bank storage; only the back bank is ever written.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NUM_WHEEL_NODES; i++) begin
          lw_x[b][i] <= '0;
          lw_y[b][i] <= '0;
          rw_x[b][i] <= '0;
          rw_y[b][i] <= '0;
        end
        for (int i = 0; i < NUM_BODY_NODES; i++) begin
          bd_x[b][i] <= '0;
          bd_y[b][i] <= '0;
        end
        cm_x[b] <= '0;
        cm_y[b] <= '0;
      end
    end else begin
      if (left_wr) begin
        lw_x[back_sel][left_cnt[WIDX_W-1:0]] <= left_wheel_x;
        lw_y[back_sel][left_cnt[WIDX_W-1:0]] <= left_wheel_y;
      end
      if (right_wr) begin
        rw_x[back_sel][right_cnt[WIDX_W-1:0]] <= right_wheel_x;
        rw_y[back_sel][right_cnt[WIDX_W-1:0]] <= right_wheel_y;
      end
      if (body_wr) begin
        bd_x[back_sel][body_cnt[BIDX_W-1:0]] <= body_x;
        bd_y[back_sel][body_cnt[BIDX_W-1:0]] <= body_y;
      end
      if (com_wr) begin
        cm_x[back_sel] <= com_x_in;
        cm_y[back_sel] <= com_y_in;
      end
    end
  end

  // Front bank read-out, selected only by the registered pointer.
  generate
    for (genvar gi = 0; gi < NUM_WHEEL_NODES; gi++) begin : g_wheel_out
      assign car_wheel_1_x[gi] = lw_x[bank_ptr][gi];
      assign car_wheel_1_y[gi] = lw_y[bank_ptr][gi];
      assign car_wheel_2_x[gi] = rw_x[bank_ptr][gi];
      assign car_wheel_2_y[gi] = rw_y[bank_ptr][gi];
    end
    for (genvar gi = 0; gi < NUM_BODY_NODES; gi++) begin : g_body_out
      assign car_body_x[gi] = bd_x[bank_ptr][gi];
      assign car_body_y[gi] = bd_y[bank_ptr][gi];
    end
  endgenerate

  assign camera_x         = cm_x[bank_ptr];
  assign camera_y         = cm_y[bank_ptr];
  assign ready_for_update = in_fill;

endmodule
`default_nettype wire

// File: tb/tb_car_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_car_frame_buffer
// Purpose  : Self-checking bench for car_frame_buffer against a queue-based
//            frame model: directed scenarios plus randomized frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_car_frame_buffer;

  localparam int W  = 17;
  localparam int NW = 4;
  localparam int NB = 3;
  localparam int EW = 8;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic signed [W-1:0] left_wheel_x = '0, left_wheel_y = '0;
  logic signed [W-1:0] right_wheel_x = '0, right_wheel_y = '0;
  logic signed [W-1:0] body_x = '0, body_y = '0;
  logic signed [W-1:0] com_x_in = '0, com_y_in = '0;
  logic left_wheel_valid = 1'b0, right_wheel_valid = 1'b0, body_valid = 1'b0;
  logic com_valid = 1'b0, all_done = 1'b0, frame_sync = 1'b0;

  logic signed [W-1:0] car_wheel_1_x [NW];
  logic signed [W-1:0] car_wheel_1_y [NW];
  logic signed [W-1:0] car_wheel_2_x [NW];
  logic signed [W-1:0] car_wheel_2_y [NW];
  logic signed [W-1:0] car_body_x [NB];
  logic signed [W-1:0] car_body_y [NB];
  logic signed [W-1:0] camera_x, camera_y;
  logic snapshot_valid, ready_for_update;
  logic [EW-1:0] frame_err_count, drop_count;

  car_frame_buffer #(
    .POSITION_SIZE(W), .NUM_WHEEL_NODES(NW), .NUM_BODY_NODES(NB), .ERR_CNT_SIZE(EW)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .left_wheel_x(left_wheel_x), .left_wheel_y(left_wheel_y), .left_wheel_valid(left_wheel_valid),
    .right_wheel_x(right_wheel_x), .right_wheel_y(right_wheel_y), .right_wheel_valid(right_wheel_valid),
    .body_x(body_x), .body_y(body_y), .body_valid(body_valid),
    .com_x_in(com_x_in), .com_y_in(com_y_in), .com_valid(com_valid),
    .all_done(all_done), .frame_sync(frame_sync),
    .car_wheel_1_x(car_wheel_1_x), .car_wheel_1_y(car_wheel_1_y),
    .car_wheel_2_x(car_wheel_2_x), .car_wheel_2_y(car_wheel_2_y),
    .car_body_x(car_body_x), .car_body_y(car_body_y),
    .camera_x(camera_x), .camera_y(camera_y),
    .snapshot_valid(snapshot_valid), .ready_for_update(ready_for_update),
    .frame_err_count(frame_err_count), .drop_count(drop_count)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_pend, m_snap, m_com_seen;
  int m_err, m_drop;
  logic signed [W-1:0] ql_x[$], ql_y[$], qr_x[$], qr_y[$], qb_x[$], qb_y[$];
  logic signed [W-1:0] m_cx, m_cy;
  logic signed [W-1:0] hl_x[NW], hl_y[NW], hr_x[NW], hr_y[NW], hb_x[NB], hb_y[NB], hc_x, hc_y;
  logic signed [W-1:0] fl_x[NW], fl_y[NW], fr_x[NW], fr_y[NW], fb_x[NB], fb_y[NB], fc_x, fc_y;

  task automatic model_reset();
    m_pend = 0; m_snap = 0; m_com_seen = 0; m_err = 0; m_drop = 0;
    ql_x.delete(); ql_y.delete(); qr_x.delete(); qr_y.delete(); qb_x.delete(); qb_y.delete();
    m_cx = '0; m_cy = '0; hc_x = '0; hc_y = '0; fc_x = '0; fc_y = '0;
    for (int i = 0; i < NW; i++) begin
      hl_x[i] = '0; hl_y[i] = '0; hr_x[i] = '0; hr_y[i] = '0;
      fl_x[i] = '0; fl_y[i] = '0; fr_x[i] = '0; fr_y[i] = '0;
    end
    for (int i = 0; i < NB; i++) begin
      hb_x[i] = '0; hb_y[i] = '0; fb_x[i] = '0; fb_y[i] = '0;
    end
  endtask

  // One clock edge of frame-level behaviour: accumulate everything, judge at all_done.
  task automatic model_clock();
    if (!m_pend) begin
      if (left_wheel_valid)  begin ql_x.push_back(left_wheel_x);  ql_y.push_back(left_wheel_y);  end
      if (right_wheel_valid) begin qr_x.push_back(right_wheel_x); qr_y.push_back(right_wheel_y); end
      if (body_valid)        begin qb_x.push_back(body_x);        qb_y.push_back(body_y);        end
      if (com_valid) begin m_cx = com_x_in; m_cy = com_y_in; m_com_seen = 1; end
      if (all_done) begin
        if (ql_x.size() == NW && qr_x.size() == NW && qb_x.size() == NB && m_com_seen) begin
          for (int i = 0; i < NW; i++) begin
            hl_x[i] = ql_x[i]; hl_y[i] = ql_y[i]; hr_x[i] = qr_x[i]; hr_y[i] = qr_y[i];
          end
          for (int i = 0; i < NB; i++) begin hb_x[i] = qb_x[i]; hb_y[i] = qb_y[i]; end
          hc_x = m_cx; hc_y = m_cy;
          m_pend = 1;
        end else if (m_err < 255) m_err++;
        ql_x.delete(); ql_y.delete(); qr_x.delete(); qr_y.delete(); qb_x.delete(); qb_y.delete();
        m_com_seen = 0;
      end
    end else begin
      if ((left_wheel_valid || right_wheel_valid || body_valid || com_valid) && m_drop < 255) m_drop++;
      if (frame_sync) begin
        fl_x = hl_x; fl_y = hl_y; fr_x = hr_x; fr_y = hr_y; fb_x = hb_x; fb_y = hb_y;
        fc_x = hc_x; fc_y = hc_y;
        m_snap = 1; m_pend = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NW; i++) begin
      check($sformatf("w1x[%0d]", i), car_wheel_1_x[i], fl_x[i]);
      check($sformatf("w1y[%0d]", i), car_wheel_1_y[i], fl_y[i]);
      check($sformatf("w2x[%0d]", i), car_wheel_2_x[i], fr_x[i]);
      check($sformatf("w2y[%0d]", i), car_wheel_2_y[i], fr_y[i]);
    end
    for (int i = 0; i < NB; i++) begin
      check($sformatf("bx[%0d]", i), car_body_x[i], fb_x[i]);
      check($sformatf("by[%0d]", i), car_body_y[i], fb_y[i]);
    end
    check("cam_x", camera_x, fc_x);
    check("cam_y", camera_y, fc_y);
    check("snapshot_valid", {31'd0, snapshot_valid}, {31'd0, m_snap});
    check("ready_for_update", {31'd0, ready_for_update}, {31'd0, !m_pend});
    check("frame_err_count", {24'd0, frame_err_count}, m_err);
    check("drop_count", {24'd0, drop_count}, m_drop);
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_clock();
    #1;
    check_all();
  endtask

  // Apply one cycle of strobes (data set by caller), then return strobes low.
  task automatic cyc(input bit lv, input bit rv, input bit bv, input bit cv, input bit ad, input bit fs);
    left_wheel_valid = lv; right_wheel_valid = rv; body_valid = bv; com_valid = cv;
    all_done = ad; frame_sync = fs;
    tick();
    left_wheel_valid = 0; right_wheel_valid = 0; body_valid = 0; com_valid = 0;
    all_done = 0; frame_sync = 0;
  endtask

  task automatic rand_data();
    left_wheel_x = W'($urandom); left_wheel_y = W'($urandom);
    right_wheel_x = W'($urandom); right_wheel_y = W'($urandom);
    body_x = W'($urandom); body_y = W'($urandom);
    com_x_in = W'($urandom); com_y_in = W'($urandom);
  endtask

  // Stream nl/nr/nb nodes in parallel, then all_done (optionally on the last
  // data cycle, optionally together with frame_sync).
  task automatic send_frame(input int nl, input int nr, input int nb, input bit with_com,
                            input bit done_on_last, input bit fs_with_done);
    int n;
    n = nl;
    if (nr > n) n = nr;
    if (nb > n) n = nb;
    if (n < 1) n = 1;
    for (int c = 0; c < n; c++) begin
      rand_data();
      if (done_on_last && c == n - 1)
        cyc(c < nl, c < nr, c < nb, with_com && c == n - 1, 1'b1, fs_with_done);
      else
        cyc(c < nl, c < nr, c < nb, with_com && c == 0, 1'b0, 1'b0);
    end
    if (!done_on_last) cyc(0, 0, 0, 0, 1'b1, fs_with_done);
  endtask

  int lx[4] = '{-50, -30, 10, 20};
  int ly[4] = '{-30, 10, 10, -30};
  int bxa[3] = '{0, 5, 10};
  int bya[3] = '{40, 45, 40};

  initial begin
    model_reset();
    #2 rst_in = 1'b0;
    #1 check_all();
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;

    // Short body stream: rejected, nothing shown.
    send_frame(4, 4, 2, 1, 0, 0);
    check("tp2_err", {24'd0, frame_err_count}, 1);
    check("tp2_snap", {31'd0, snapshot_valid}, 0);
    // One extra left node: rejected.
    send_frame(5, 4, 3, 1, 0, 0);
    check("tp3_err", {24'd0, frame_err_count}, 2);

    // Known car.
    for (int i = 0; i < 4; i++) begin
      left_wheel_x = W'(lx[i]); left_wheel_y = W'(ly[i]);
      right_wheel_x = W'(lx[i] + 100); right_wheel_y = W'(ly[i]);
      body_x = (i < 3) ? W'(bxa[i]) : '0; body_y = (i < 3) ? W'(bya[i]) : '0;
      com_x_in = W'(7); com_y_in = W'(2);
      cyc(1, 1, i < 3, i == 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 1, 0);
    check("tp1_ready_low", {31'd0, ready_for_update}, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    check("tp1_snap", {31'd0, snapshot_valid}, 1);
    check("tp1_ready", {31'd0, ready_for_update}, 1);
    for (int i = 0; i < 4; i++) check("tp1_w1x", car_wheel_1_x[i], lx[i]);
    for (int i = 0; i < 3; i++) check("tp1_by", car_body_y[i], bya[i]);
    check("tp1_camx", camera_x, 7);
    check("tp1_camy", camera_y, 2);

    // Drops while pending.
    send_frame(4, 4, 3, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin rand_data(); cyc(0, 0, 1, 0, 0, 0); end
    check("tp4_drop", {24'd0, drop_count}, 3);
    cyc(0, 0, 0, 0, 0, 1);

    // all_done together with frame_sync: swap waits for the next sync.
    send_frame(4, 4, 3, 1, 1, 1);
    check("tp5_pending", {31'd0, ready_for_update}, 0);
    repeat (19) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    check("tp5_swapped", {31'd0, ready_for_update}, 1);

    // Randomized frames.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) != 0)
        send_frame(NW, NW, NB, 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
      else
        send_frame($urandom_range(2, 5), $urandom_range(3, 5), $urandom_range(1, 4),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 0);
      for (int k = 0; k < int'($urandom_range(0, 5)); k++) begin
        rand_data();
        cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, 0, 0);
      end
      if ($urandom_range(0, 3) != 0) cyc(0, 0, 0, 0, 0, 1);
    end

    // Asynchronous reset mid-frame.
    for (int i = 0; i < 2; i++) begin rand_data(); cyc(1, 0, 0, 0, 0, 0); end
    #3 rst_in = 1'b0;
    model_reset();
    #1 check_all();
    check("tp6_camx", camera_x, 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    send_frame(NW, NW, NB, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    check("tp6_snap", {31'd0, snapshot_valid}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
